lsu_mem_controller: RTL and testbench

LSU_MEM_CONTROLLER -- requirements
Module: lsu_mem_controller

---
 rtl/lsu_mem_controller.sv | 189 ++++++++++++++++++
 tb/tb_lsu_mem_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_controller.sv
// ---------------------------------------------------------------------------
// lsu_mem_controller
// Load/store unit front end between a core request port and a single-port
// word-wide data memory with combinational read. Handles RV32I byte/half/word
// loads (sign or zero extended), word stores, and byte/half stores via a
// read-modify-write. Illegal, misaligned or out-of-range requests respond
// with rsp_err and never write memory.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3       store flag, RV32I width code
//   req_addr, req_wdata      byte address, right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response pulse
//   mem_addr, mem_dataW      word-aligned memory address, write data
//   mem_MemRW, mem_dataR     write strobe, combinational read data
// ---------------------------------------------------------------------------
module lsu_mem_controller #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataW,
    output logic        mem_MemRW,
    input  logic [31:0] mem_dataR
);

    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [2:0]      r_funct3;
    logic [DW-1:0]   r_addr;
    logic [15:0]     r_wdata;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [DW-1:0]   r_rsp_rdata;
    logic [DW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_dataW;
    logic            r_mem_we;

    logic            w_err;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [DW-1:0]   w_load;
    logic [DW-1:0]   w_merged;

    // Request classification on the incoming request
    always_comb begin
        w_err = 1'b0;
        if (!req_we && (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111))
            w_err = 1'b1;
        if (req_we && !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010))
            w_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            w_err = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            w_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= DW'(DEPTH_WORDS))
            w_err = 1'b1;
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        w_byte   = 8'h00;
        w_half   = r_addr[1] ? mem_dataR[31:16] : mem_dataR[15:0];
        w_load   = mem_dataR;
        w_merged = mem_dataR;
        case (r_addr[1:0])
            2'd0:    w_byte = mem_dataR[7:0];
            2'd1:    w_byte = mem_dataR[15:8];
            2'd2:    w_byte = mem_dataR[23:16];
            default: w_byte = mem_dataR[31:24];
        endcase
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h000000, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0000, w_half};
            default: w_load = mem_dataR;
        endcase
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0]  = r_wdata;
        end
    end

    // Controller FSM; memory-side and response outputs are set on entry to each state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_mem_dataW <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata[15:0];
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (!req_we) begin
                            r_mem_addr <= {req_addr[31:2], 2'b00};
                            r_state    <= S_READ;
                        end else if (req_funct3 == 3'b010) begin
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_dataW <= req_wdata;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_WRITE;
                        end else begin
                            r_mem_addr <= {req_addr[31:2], 2'b00};
                            r_state    <= S_RMW_READ;
                        end
                    end
                end
                S_READ: begin
                    r_rsp_rdata <= w_load;
                    r_rsp_valid <= 1'b1;
                    r_mem_addr  <= '0;
                    r_state     <= S_RESP;
                end
                S_RMW_READ: begin
                    r_mem_dataW <= w_merged;
                    r_mem_we    <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_mem_we    <= 1'b0;
                    r_mem_dataW <= '0;
                    r_mem_addr  <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset gates the strobes directly so a reset edge during WRITE never writes
    assign req_ready = (r_state == S_IDLE) && !rst;
    assign mem_MemRW = r_mem_we && !rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_dataW = r_mem_dataW;

endmodule

// File: tb/tb_lsu_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_controller
// Scoreboard bench: the driver pushes the reference-model response for every
// accepted request; an independent monitor compares responses, memory writes
// and req_ready every cycle. Includes the directed scenarios and a random run.
// ---------------------------------------------------------------------------
module tb_lsu_mem_controller;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataW;
    logic        mem_MemRW;
    logic [31:0] mem_dataR;

    lsu_mem_controller #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_dataW  (mem_dataW),
        .mem_MemRW  (mem_MemRW),
        .mem_dataR  (mem_dataR)
    );

    // Attached data memory
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    assign mem_dataR = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_MemRW) mem[mem_addr[11:2]] <= mem_dataW;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: RV32I load/store semantics on a word array
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          nb;
        int          sh;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] v;
        e.rdata = 0; e.err = 0; e.lat = 0; e.wr = 0; e.wdata = 0; e.acc = 0;
        e.waddr = a & ~32'd3;
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.err = !legal || ((a % nb) != 0) || ((a >> 2) >= DEPTH);
        if (e.err) begin
            e.lat = 1;
            return e;
        end
        sh   = 8 * int'(a % 4);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        word = ref_mem[a[11:2]];
        if (!we) begin
            v = (word >> sh) & mask;
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
            e.rdata = v;
            e.lat   = 2;
        end else begin
            v = (word & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[a[11:2]] = v;
            e.wr    = 1;
            e.wdata = v;
            e.lat   = (nb == 4) ? 2 : 3;
        end
        return e;
    endfunction

    // Drive one request; hold keeps req_valid high for a back-to-back follow-up
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e = model(we, f3, a, wd);
        e.acc = cyc;
        @(posedge clk);
        q.push_back(e);
        if (!hold) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Monitor: req_ready, memory writes and responses against the scoreboard
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            #2;
            chk("req_ready", 32'(req_ready), 32'((q.size() == 0) && !rst));
            if (mem_MemRW) begin
                ok = (q.size() != 0) ? q[0].wr : 1'b0;
                chk("write_allowed", 32'(ok), 32'd1);
                if (ok) begin
                    chk("write_addr", mem_addr, q[0].waddr);
                    chk("write_data", mem_dataW, q[0].wdata);
                end
            end
            if (rsp_valid) begin
                chk("rsp_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end else begin
                chk("rsp_idle", {rsp_rdata[31:1], rsp_rdata[0] | rsp_err}, 32'd0);
                if (q.size() != 0 && (cyc - q[0].acc) > 6) begin
                    chk("rsp_timeout", 32'(cyc - q[0].acc), 32'(q[0].lat));
                    void'(q.pop_front());
                end
            end
        end
    end

    logic [31:0] saved;
    logic        rw;
    logic [2:0]  rf3;
    logic [31:0] ra;
    int          n;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_mem_we", 32'(mem_MemRW), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_dataW", mem_dataW, 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // Word store/load
        send(1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        send(0, 3'b010, 32'h10, 32'h0, 0);
        // Byte lane store and extended loads
        send(1, 3'b010, 32'h10, 32'h11223344, 0);
        send(1, 3'b000, 32'h12, 32'hFFFFFFAA, 0);
        send(0, 3'b000, 32'h12, 32'h0, 0);
        send(0, 3'b100, 32'h12, 32'h0, 0);
        send(0, 3'b010, 32'h10, 32'h0, 0);
        // Half store and extended loads
        send(1, 3'b001, 32'h12, 32'h12348001, 0);
        send(0, 3'b001, 32'h12, 32'h0, 0);
        send(0, 3'b101, 32'h12, 32'h0, 0);
        send(0, 3'b010, 32'h10, 32'h0, 0);
        // Rejected requests
        send(1, 3'b010, 32'h13, 32'h55555555, 0);
        send(0, 3'b001, 32'h11, 32'h0, 0);
        send(0, 3'b011, 32'h10, 32'h0, 0);
        send(1, 3'b010, 32'(4 * DEPTH), 32'h66666666, 0);
        send(1, 3'b100, 32'h10, 32'h77777777, 0);
        send(0, 3'b010, 32'h10, 32'h0, 0);

        // Reset while the byte store sits in WRITE: no write, no response
        saved = ref_mem[4];
        send(1, 3'b000, 32'h11, 32'h000000EE, 0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        ref_mem[4] = saved;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_mem_dataW", mem_dataW, 32'd0);
        send(0, 3'b010, 32'h10, 32'h0, 0);

        // Back-to-back with req_valid held high
        send(1, 3'b010, 32'h20, 32'hCAFEF00D, 1);
        send(1, 3'b000, 32'h21, 32'h00000012, 1);
        send(0, 3'b000, 32'h21, 32'h0, 1);
        send(0, 3'b011, 32'h20, 32'h0, 1);
        send(0, 3'b010, 32'h20, 32'h0, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                n = $urandom_range(0, rw ? 2 : 4);
                rf3 = 3'((n > 2) ? n + 1 : n);
            end
            case ($urandom_range(0, 9))
                0:       ra = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
                1:       ra = $urandom;
                default: ra = 32'($urandom_range(0, 255));
            endcase
            send(rw, rf3, ra, $urandom, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        req_valid = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 80; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
